uart_host_driver: RTL and testbench
===================================

# uart_host_driver

Bus-side initiator for the UART peripheral's 2-bit register interface. It programs the baud divisor after reset, then drains a byte FIFO into the transmitter with one TX_DATA write, an enable, a fixed frame wait and a disable per byte. It also services host read requests by issuing RX_DATA read cycles. It sits between host logic and the UART register port, so host logic never sequences register accesses itself.

## Interface
Parameters:
- BAUD_DIV, 32'd434, value written to the BAUD_RATE register at init.
- FRAME_CYCLES, 4340, clocks the enable stays high per byte (≥1, fits in 16 bits).
- FIFO_DEPTH, 8, byte FIFO depth (power of 2, ≥2).

Ports:
- clk  input  1  system clock; single clock domain; all logic on its rising edge.
- rst  input  1  reset; asynchronous, active-low.
- s_data  input  8  byte to transmit.
- s_valid  input  1  s_data valid; pushed when s_valid & s_ready.
- s_ready  output  1  FIFO not full.
- rd_req  input  1  one-cycle pulse requesting an RX_DATA read.
- rd_data  output  8  last byte read; held until the next read completes.
- rd_valid  output  1  one-cycle pulse when rd_data updates.
- busy  output  1  state ≠ IDLE, FIFO non-empty, or read pending.
- address  output  2  register address: 00 baud, 01 tx enable, 10 tx data, 11 rx data.
- write_enable  output  1  register write strobe.
- write_data  output  32  register write data.
- read_enable  output  1  register read strobe.
- read_data  input  8  peripheral read data; valid during the read_enable cycle.

## Operation
- All bus outputs, rd_data and rd_valid are registered. Reset values: address 00, write_enable 0, write_data 0, read_enable 0, rd_data 00, rd_valid 0, busy 1. FIFO empty, so s_ready 1.
- FSM states: INIT_BAUD, INIT_DIS, IDLE, LOAD, EN, WAIT, DIS, READ. Each state except WAIT and IDLE drives exactly one bus cycle.
- INIT_BAUD: write address 00, data BAUD_DIV. Next state is INIT_DIS.
- INIT_DIS: write address 01, data 0. Next state is IDLE.
- IDLE: if a read is pending, go to READ. Otherwise, if the FIFO is non-empty, go to LOAD. Reads have priority.
- LOAD: pop the FIFO head and write address 10, data {24'b0, byte}. Next state is EN.
- EN: write address 01, data 1. Load a counter with FRAME_CYCLES. Next state is WAIT.
- WAIT: no bus activity (write_enable 0, read_enable 0). Decrement the counter. When the counter reaches 1, go to DIS.
- DIS: write address 01, data 0. Next state is IDLE.
- READ: drive read_enable 1 and address 11. Capture read_data into rd_data at the end of the cycle. Pulse rd_valid in the following cycle, then return to IDLE.
- Pending read flag: set by rd_req in any state, cleared on entry to READ. Multiple requests while pending collapse into one read.
- FIFO: rd/wr pointers are log2(FIFO_DEPTH)+1 bits with natural wrap. Push and pop in the same cycle leave the count unchanged. A push when full is ignored (s_ready is 0). A pop occurs only in LOAD, never when empty.
- write_enable and read_enable are never both 1 in the same cycle.

## Timing
- Reset release: INIT_BAUD write in cycle 1, INIT_DIS write in cycle 2, IDLE from cycle 3.
- Byte latency: a byte pushed at edge E into an empty FIFO with the FSM in IDLE gives LOAD in cycle E+1 and EN in cycle E+2. WAIT lasts FRAME_CYCLES cycles, then DIS follows.
- Per-byte bus occupancy is FRAME_CYCLES+3 cycles. Back-to-back bytes have one IDLE cycle between DIS and the next LOAD.
- Read latency: rd_req sampled at edge E in IDLE gives READ in cycle E+2 (IDLE at E+1) and rd_valid in cycle E+3.
- A read requested during WAIT is deferred until after DIS. The transmitted frame is never truncated.
- rst asserted mid-operation: all outputs return to reset values immediately, the FIFO and pending read are cleared, and init reruns after release.

## Test plan
Bench parameters: BAUD_DIV=4, FRAME_CYCLES=20, FIFO_DEPTH=4.
- Reset release: expect write 00 = 0x00000004 in cycle 1, then 01 = 0 in cycle 2, then no bus activity while idle.
- Push byte 0xA5: expect writes 10 = 0x000000A5, then 01 = 1, then 20 idle cycles, then 01 = 0. busy drops in the cycle after DIS.
- Push 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back: expect s_ready to drop once 4 bytes are buffered. Exactly five TX_DATA writes occur in order, spaced FRAME_CYCLES+4 cycles apart.
- read_data=0x3C, pulse rd_req in IDLE: expect read_enable with address 11 two cycles later, then rd_valid for one cycle with rd_data=0x3C.
- rd_req twice during WAIT of byte 0x77: expect no read until after the disable write, then exactly one READ before the next LOAD.
- Assert rst during WAIT with 2 bytes queued: expect all outputs at reset values, init rerun after release, and no TX_DATA writes afterwards.

Source files
------------

// File: rtl/uart_host_driver.sv
// UART register-port initiator: baud init, byte FIFO drain to TX,
// and host-requested RX_DATA reads.
module uart_host_driver #(
   parameter logic [31:0] BAUD_DIV     = 32'd434,
   parameter int          FRAME_CYCLES = 4340,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        rd_req,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic [1:0]  address,
   output logic        write_enable,
   output logic [31:0] write_data,
   output logic        read_enable,
   input  logic [7:0]  read_data
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [15:0] FRAME_LD = 16'(FRAME_CYCLES);

   localparam logic [1:0] A_BAUD = 2'b00;
   localparam logic [1:0] A_EN   = 2'b01;
   localparam logic [1:0] A_TX   = 2'b10;
   localparam logic [1:0] A_RX   = 2'b11;

   typedef enum logic [2:0] {
      INIT_BAUD,
      INIT_DIS,
      IDLE,
      LOAD,
      EN,
      WAIT,
      DIS,
      READ
   } state_t;

   state_t      state;
   state_t      state_d;

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;

   logic        pend;
   logic [15:0] cnt;

   logic [1:0]  addr_d;
   logic        we_d;
   logic        re_d;
   logic [31:0] wd_d;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign s_ready = ~full;
   assign push    = s_valid & ~full;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= s_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= INIT_BAUD;
      else      state <= state_d;
   end

   // Bus fields are decoded from the current state and registered,
   // so each bus cycle appears one clock after its state.
   // A push landing this edge counts as non-empty for the IDLE decision.
   always_comb begin
      state_d = state;
      addr_d  = A_BAUD;
      we_d    = 1'b0;
      re_d    = 1'b0;
      wd_d    = '0;
      pop     = 1'b0;
      unique case (state)
         INIT_BAUD: begin
            we_d    = 1'b1;
            addr_d  = A_BAUD;
            wd_d    = BAUD_DIV;
            state_d = INIT_DIS;
         end
         INIT_DIS: begin
            we_d    = 1'b1;
            addr_d  = A_EN;
            state_d = IDLE;
         end
         IDLE: begin
            if (pend)                state_d = READ;
            else if (!empty || push) state_d = LOAD;
         end
         LOAD: begin
            we_d    = 1'b1;
            addr_d  = A_TX;
            wd_d    = {24'b0, mem[rd_ptr[AW-1:0]]};
            pop     = 1'b1;
            state_d = EN;
         end
         EN: begin
            we_d    = 1'b1;
            addr_d  = A_EN;
            wd_d    = 32'd1;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt == 16'd1) state_d = DIS;
         end
         DIS: begin
            we_d    = 1'b1;
            addr_d  = A_EN;
            state_d = IDLE;
         end
         READ: begin
            re_d    = 1'b1;
            addr_d  = A_RX;
            state_d = IDLE;
         end
         default: state_d = INIT_BAUD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state == EN) begin
         cnt <= FRAME_LD;
      end else if (state == WAIT) begin
         cnt <= cnt - 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 pend <= 1'b0;
      else if (rd_req)          pend <= 1'b1;
      else if (state_d == READ) pend <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         address      <= A_BAUD;
         write_enable <= 1'b0;
         write_data   <= '0;
         read_enable  <= 1'b0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         busy         <= 1'b1;
      end else begin
         address      <= addr_d;
         write_enable <= we_d;
         write_data   <= wd_d;
         read_enable  <= re_d;
         rd_valid     <= read_enable;
         if (read_enable) rd_data <= read_data;
         busy         <= (state != IDLE) || !empty || pend;
      end
   end

endmodule

// File: tb/tb_uart_host_driver.sv
// Directed bench for uart_host_driver: cycle tables for init, TX and
// read, plus hand sequences for FIFO full, deferred read and reset.
module tb_uart_host_driver;

   localparam logic O = 1'b0;
   localparam logic I = 1'b1;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        rd_req;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        busy;
   logic [1:0]  address;
   logic        write_enable;
   logic [31:0] write_data;
   logic        read_enable;
   logic [7:0]  read_data;

   uart_host_driver #(
      .BAUD_DIV     (32'd4),
      .FRAME_CYCLES (20),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .rd_req       (rd_req),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .busy         (busy),
      .address      (address),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_enable  (read_enable),
      .read_data    (read_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sv;
      logic [7:0]  sd;
      logic        rq;
      logic [7:0]  rdd;
      logic [1:0]  a;
      logic        we;
      logic [31:0] wd;
      logic        re;
      logic        rv;
      logic [7:0]  rdo;
      logic        bz;
      logic        sr;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [1:0]  a;
      logic [31:0] d;
   } wr_t;

   vec_t vt [12];
   logic [7:0] bb [5];

   wr_t wr_log [$];
   wr_t tx_log [$];
   int  dis_log [$];
   int  rd_log [$];
   int  rv_count = 0;
   logic both_seen = 1'b0;
   int  cyc = 0;

   int total = 0;
   int bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (write_enable) begin
         wr_log.push_back('{cyc, address, write_data});
         if (address == 2'd2)
            tx_log.push_back('{cyc, address, write_data});
         if (address == 2'd1 && write_data == 32'd0)
            dis_log.push_back(cyc);
      end
      if (read_enable) rd_log.push_back(cyc);
      if (rd_valid) rv_count = rv_count + 1;
      if (write_enable && read_enable) both_seen = 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         s_valid   = vt[i].sv;
         s_data    = vt[i].sd;
         rd_req    = vt[i].rq;
         read_data = vt[i].rdd;
         @(negedge clk);
         chk($sformatf("v%0d addr", i), 32'(address), 32'(vt[i].a));
         chk($sformatf("v%0d we", i), 32'(write_enable), 32'(vt[i].we));
         chk($sformatf("v%0d wd", i), write_data, vt[i].wd);
         chk($sformatf("v%0d re", i), 32'(read_enable), 32'(vt[i].re));
         chk($sformatf("v%0d rv", i), 32'(rd_valid), 32'(vt[i].rv));
         chk($sformatf("v%0d rd", i), 32'(rd_data), 32'(vt[i].rdo));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].bz));
         chk($sformatf("v%0d srdy", i), 32'(s_ready), 32'(vt[i].sr));
      end
      s_valid = O;
      rd_req  = O;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " addr"}, 32'(address), 32'd0);
      chk({tag, " we"}, 32'(write_enable), 32'd0);
      chk({tag, " wd"}, write_data, 32'd0);
      chk({tag, " re"}, 32'(read_enable), 32'd0);
      chk({tag, " rd"}, 32'(rd_data), 32'd0);
      chk({tag, " rv"}, 32'(rd_valid), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " srdy"}, 32'(s_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int r0;
      int nq;
      int x;

      // sv sd rq rdd | a we wd re rv rdo busy srdy
      vt[0]  = '{O, 8'h00, O, 8'h00, 2'd0, I, 32'h4,  O, O, 8'h00, I, I};
      vt[1]  = '{O, 8'h00, O, 8'h00, 2'd1, I, 32'h0,  O, O, 8'h00, I, I};
      vt[2]  = '{O, 8'h00, O, 8'h00, 2'd0, O, 32'h0,  O, O, 8'h00, O, I};
      vt[3]  = '{I, 8'hA5, O, 8'h00, 2'd0, O, 32'h0,  O, O, 8'h00, O, I};
      vt[4]  = '{O, 8'h00, O, 8'h00, 2'd2, I, 32'hA5, O, O, 8'h00, I, I};
      vt[5]  = '{O, 8'h00, O, 8'h00, 2'd1, I, 32'h1,  O, O, 8'h00, I, I};
      vt[6]  = '{O, 8'h00, O, 8'h00, 2'd0, O, 32'h0,  O, O, 8'h00, I, I};
      vt[7]  = '{O, 8'h00, I, 8'h00, 2'd0, O, 32'h0,  O, O, 8'h00, O, I};
      vt[8]  = '{O, 8'h00, O, 8'h00, 2'd0, O, 32'h0,  O, O, 8'h00, I, I};
      vt[9]  = '{O, 8'h00, O, 8'h3C, 2'd3, O, 32'h0,  I, O, 8'h00, I, I};
      vt[10] = '{O, 8'h00, O, 8'h3C, 2'd0, O, 32'h0,  O, I, 8'h3C, O, I};
      vt[11] = '{O, 8'h00, O, 8'h99, 2'd0, O, 32'h0,  O, O, 8'h3C, O, I};

      bb[0] = 8'h11;
      bb[1] = 8'h22;
      bb[2] = 8'h33;
      bb[3] = 8'h44;
      bb[4] = 8'h55;

      rst       = O;
      s_valid   = O;
      s_data    = 8'h00;
      rd_req    = O;
      read_data = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_vals("por");

      // init sequence, byte 0xA5 up to first WAIT cycle
      rst = I;
      run_vecs(0, 6);
      nq = 0;
      repeat (19) begin
         @(negedge clk);
         if (write_enable || read_enable) nq = nq + 1;
      end
      chk("a5 wait quiet", nq, 0);
      @(negedge clk);
      chk("a5 dis addr", 32'(address), 32'd1);
      chk("a5 dis we", 32'(write_enable), 32'd1);
      chk("a5 dis wd", write_data, 32'd0);
      @(negedge clk);
      chk("a5 busy drop", 32'(busy), 32'd0);

      // read in IDLE
      run_vecs(7, 11);

      // back-to-back bytes and FIFO full
      tx_log.delete();
      p0 = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) chk("b2b ready pre", 32'(s_ready), 32'd1);
         s_valid = I;
         s_data  = bb[i];
         @(negedge clk);
         if (i == 0) p0 = cyc;
      end
      chk("b2b full", 32'(s_ready), 32'd0);
      s_data = 8'h66;
      repeat (5) @(negedge clk);
      chk("b2b full hold", 32'(s_ready), 32'd0);
      s_valid = O;
      repeat (140) @(negedge clk);
      chk("b2b tx count", tx_log.size(), 5);
      for (int k = 0; k < 5; k++) begin
         x = (tx_log.size() > k) ? tx_log[k].cyc : -1;
         chk($sformatf("b2b tx%0d cyc", k), x, p0 + 1 + 24 * k);
         x = (tx_log.size() > k) ? int'(tx_log[k].d) : -1;
         chk($sformatf("b2b tx%0d data", k), x, 32'(bb[k]));
      end
      chk("b2b idle busy", 32'(busy), 32'd0);

      // reads requested during WAIT are deferred past DIS
      tx_log.delete();
      rd_log.delete();
      dis_log.delete();
      rv_count = 0;
      s_valid = I;
      s_data  = 8'h77;
      @(negedge clk);
      p0 = cyc;
      s_valid = O;
      repeat (6) @(negedge clk);
      rd_req = I;
      @(negedge clk);
      rd_req = O;
      repeat (4) @(negedge clk);
      rd_req = I;
      @(negedge clk);
      rd_req = O;
      s_valid = I;
      s_data  = 8'h88;
      @(negedge clk);
      s_valid = O;
      chk("wr no early read", rd_log.size(), 0);
      repeat (50) @(negedge clk);
      chk("wr read count", rd_log.size(), 1);
      chk("wr rv count", rv_count, 1);
      chk("wr tx count", tx_log.size(), 2);
      x = (dis_log.size() > 0) ? dis_log[0] : -1;
      chk("wr dis cyc", x, p0 + 23);
      x = (rd_log.size() > 0) ? rd_log[0] : -1;
      chk("wr read cyc", x, p0 + 25);
      x = (tx_log.size() > 1) ? tx_log[1].cyc : -1;
      chk("wr load2 cyc", x, p0 + 27);
      x = (tx_log.size() > 1) ? int'(tx_log[1].d) : -1;
      chk("wr load2 data", x, 32'h88);

      // reset during WAIT with two bytes queued
      s_valid = I;
      s_data  = 8'h91;
      @(negedge clk);
      s_data  = 8'h92;
      @(negedge clk);
      s_data  = 8'h93;
      @(negedge clk);
      s_valid = O;
      repeat (5) @(negedge clk);
      #2 rst = O;
      #1;
      chk_reset_vals("mid");
      wr_log.delete();
      tx_log.delete();
      repeat (3) @(negedge clk);
      rst = I;
      r0 = cyc;
      repeat (60) @(negedge clk);
      chk("mid wr count", wr_log.size(), 2);
      x = (wr_log.size() > 0) ? wr_log[0].cyc : -1;
      chk("mid baud cyc", x, r0 + 1);
      x = (wr_log.size() > 0) ? int'(wr_log[0].a) : -1;
      chk("mid baud addr", x, 0);
      x = (wr_log.size() > 0) ? int'(wr_log[0].d) : -1;
      chk("mid baud data", x, 4);
      x = (wr_log.size() > 1) ? wr_log[1].cyc : -1;
      chk("mid dis cyc", x, r0 + 2);
      x = (wr_log.size() > 1) ? int'(wr_log[1].a) : -1;
      chk("mid dis addr", x, 1);
      chk("mid tx none", tx_log.size(), 0);
      chk("mid busy", 32'(busy), 32'd0);
      chk("mid srdy", 32'(s_ready), 32'd1);

      chk("rw exclusive", 32'(both_seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
